// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/ready
// handshake and resolves branch/jump targets from control_unit.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        b_beq,
  input  logic        b_jal,
  input  logic        b_jalr,
  input  logic        alu_zero,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic        misaligned
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    ISSUE,
    HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q;
  logic        mis_q, mis_d;
  logic [31:0] next_pc;

  always_comb begin
    next_pc = pc_q + 32'd4;
    if (b_jalr) begin
      next_pc = alu_result & ~32'h1;
    end else if (b_jal || (b_beq && alu_zero)) begin
      next_pc = pc_q + imm;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    mis_d   = mis_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH, WAIT: begin
        if (imem_ready) begin
          inst_d  = imem_rdata;
          state_d = ISSUE;
        end else begin
          state_d = WAIT;
        end
      end
      ISSUE: begin
        if (!stall) begin
          pc_d   = next_pc;
          inst_d = NOP_INST;
          // A misaligned target still lands in pc so it can be inspected
          if (next_pc[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = HALT;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= (state_d == ISSUE);
      mis_q   <= mis_d;
    end
  end

  assign imem_req   = (state_q == FETCH) || (state_q == WAIT);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + 32'd4;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences
// and a randomized run against a per-instruction reference model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall = 1'b0;
  logic        b_beq = 1'b0;
  logic        b_jal = 1'b0;
  logic        b_jalr = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] alu_result = '0;
  logic        misaligned;

  int errors = 0;
  int checks = 0;
  logic [31:0] mpc;

  fetch_unit #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .inst(inst), .inst_valid(inst_valid),
    .pc(pc), .pc_plus4(pc_plus4), .stall(stall),
    .b_beq(b_beq), .b_jal(b_jal), .b_jalr(b_jalr),
    .alu_zero(alu_zero), .imm(imm), .alu_result(alu_result),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          w;
    int          s;
    logic        jal;
    logic        jalr;
    logic        beq;
    logic        zero;
    logic [31:0] imm;
    logic [31:0] alur;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h4) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  function automatic logic [31:0] ref_next(
    input logic [31:0] p, input logic jal, input logic jalr,
    input logic beq, input logic zero,
    input logic [31:0] im, input logic [31:0] ar);
    if (jalr) return {ar[31:1], 1'b0};
    if (jal || (beq && zero)) return p + im;
    return p + 32'd4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic junk();
    b_beq      = 1'($urandom);
    b_jal      = 1'($urandom);
    b_jalr     = 1'($urandom);
    alu_zero   = 1'($urandom);
    imm        = $urandom;
    alu_result = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    junk();
    imem_ready = 1'($urandom);
    step();
    step();
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_mis", 32'(misaligned), 32'h0);
    rst = 1'b0;
  endtask

  // Starts at a FETCH cycle, ends on the final ISSUE cycle with
  // the resolving inputs driven (edge not yet taken).
  task automatic run_inst(input int w, input int s,
    input logic jal, input logic jalr, input logic beq,
    input logic zero, input logic [31:0] im,
    input logic [31:0] ar, output logic [31:0] nxt);
    for (int i = 0; i <= w; i++) begin
      chk("f_req", 32'(imem_req), 32'h1);
      chk("f_addr", imem_addr, mpc);
      chk("f_valid", 32'(inst_valid), 32'h0);
      junk();
      stall      = 1'($urandom);
      imem_ready = (i == w);
      imem_rdata = (i == w) ? mem(mpc) : $urandom;
      step();
    end
    for (int j = 0; j <= s; j++) begin
      chk("i_valid", 32'(inst_valid), 32'h1);
      chk("i_inst", inst, mem(mpc));
      chk("i_pc", pc, mpc);
      chk("i_pc4", pc_plus4, mpc + 32'd4);
      chk("i_req", 32'(imem_req), 32'h0);
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      if (j < s) begin
        junk();
        stall = 1'b1;
        step();
      end else begin
        stall = 1'b0;
        b_jal = jal; b_jalr = jalr; b_beq = beq;
        alu_zero = zero; imm = im; alu_result = ar;
      end
    end
    nxt = ref_next(mpc, jal, jalr, beq, zero, im, ar);
  endtask

  task automatic halt_check(input logic [31:0] p, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      chk("h_pc", pc, p);
      chk("h_mis", 32'(misaligned), 32'h1);
      chk("h_req", 32'(imem_req), 32'h0);
      chk("h_valid", 32'(inst_valid), 32'h0);
      junk();
      stall = 1'($urandom);
      imem_ready = 1'($urandom);
    end
  endtask

  vec_t tbl[$];
  logic [31:0] nxt;

  initial begin
    tbl = '{
      '{0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4},
      '{3, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8},
      '{0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hC},
      '{1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h10},
      '{0, 0, 0, 0, 1, 1, 32'hFFFF_FFF8, 32'h0, 32'h8},
      '{0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'hC},
      '{0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h10},
      '{0, 0, 0, 0, 1, 0, 32'hFFFF_FFF8, 32'h0, 32'h14},
      '{0, 0, 1, 1, 0, 0, 32'h40, 32'h101, 32'h100},
      '{2, 0, 0, 1, 1, 1, 32'h8, 32'h21, 32'h20},
      '{0, 3, 1, 0, 0, 0, 32'h40, 32'h0, 32'h60},
      '{0, 0, 1, 0, 1, 0, 32'hFFFF_FFA0, 32'h0, 32'h0},
      '{0, 0, 0, 1, 0, 0, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFC},
      '{1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0}
    };

    do_reset();
    step();
    mpc = 32'h0;
    foreach (tbl[i]) begin
      run_inst(tbl[i].w, tbl[i].s, tbl[i].jal, tbl[i].jalr,
               tbl[i].beq, tbl[i].zero, tbl[i].imm, tbl[i].alur, nxt);
      step();
      chk("vec_addr", imem_addr, tbl[i].exp);
      mpc = tbl[i].exp;
    end

    run_inst(0, 0, 1, 0, 0, 0, 32'h6, 32'h0, nxt);
    halt_check(32'h6, 10);
    do_reset();
    step();
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_req", 32'(imem_req), 32'h1);

    imem_ready = 1'b0;
    step();
    chk("wait_req", 32'(imem_req), 32'h1);
    rst = 1'b1;
    step();
    chk("wrst_req", 32'(imem_req), 32'h0);
    chk("wrst_pc", pc, 32'h0);
    chk("wrst_valid", 32'(inst_valid), 32'h0);
    rst = 1'b0;
    step();
    imem_ready = 1'b1;
    imem_rdata = mem(32'h0);
    step();
    chk("irst_valid0", 32'(inst_valid), 32'h1);
    stall = 1'b1;
    rst = 1'b1;
    step();
    chk("irst_valid", 32'(inst_valid), 32'h0);
    chk("irst_inst", inst, NOP);
    chk("irst_req", 32'(imem_req), 32'h0);
    rst = 1'b0;

    do_reset();
    step();
    mpc = 32'h0;
    for (int n = 0; n < 200; n++) begin
      logic [31:0] ri, ra;
      ri = $urandom_range(0, 15) == 0 ? $urandom : ($urandom & ~32'h3);
      ra = $urandom_range(0, 15) == 0 ? $urandom : ($urandom & ~32'h2);
      run_inst($urandom_range(0, 3), $urandom_range(0, 2),
               1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 3) == 0),
               1'($urandom), 1'($urandom), ri, ra, nxt);
      if (nxt[1:0] != 2'b00) begin
        halt_check(nxt, 2);
        do_reset();
        step();
        mpc = 32'h0;
      end else begin
        step();
        mpc = nxt;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of control_unit in the RISC-V core. Holds the PC and fetches the instruction word from instruction memory over a req/ready handshake. Presents the word to control_unit and consumes control_unit's branch/jump decisions (b_beq, b_jal, b_jalr) plus datapath results to compute the next PC. Built as a small FSM so that variable-latency instruction memory is supported.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, value driven on inst when no valid instruction is held (addi x0,x0,0).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address, always equal to pc
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  memory accepts request and returns data this cycle
inst  output  32  instruction to control_unit and immediate generator
inst_valid  output  1  inst holds a fetched instruction being executed
pc  output  32  address of inst
pc_plus4  output  32  pc+4 (combinational), used as jal/jalr link value
stall  input  1  hold current instruction in ISSUE
b_beq  input  1  from control_unit
b_jal  input  1  from control_unit
b_jalr  input  1  from control_unit
alu_zero  input  1  ALU zero flag for beq
imm  input  32  sign-extended immediate from immediate generator
alu_result  input  32  ALU result (rs1+imm) for jalr target
misaligned  output  1  sticky misaligned-target error

Behaviour:
- Reset state: the clock and reset are one clk and one rst; rst is synchronous and active-high. While rst=1 at a clk edge: state=IDLE, pc=RESET_PC, inst=NOP_INST, inst_valid=0, misaligned=0. imem_req=0 in IDLE.
- States:
  - IDLE: imem_req=0. Next state is FETCH unconditionally.
  - FETCH: imem_req=1, imem_addr=pc. If imem_ready=1, capture imem_rdata into inst and go to ISSUE. Otherwise go to WAIT.
  - WAIT: imem_req=1, imem_addr unchanged. Go to ISSUE with capture on imem_ready=1. Otherwise stay in WAIT.
  - ISSUE: inst_valid=1, imem_req=0.
    - If stall=1: pc, inst and state are held.
    - If stall=0: load pc with next_pc, set inst=NOP_INST and inst_valid=0, and go to FETCH.
  - HALT: imem_req=0, inst_valid=0, misaligned=1. Exit only via rst.
- inst_valid is registered and equals (state==ISSUE).
- next_pc priority:
  - b_jalr: (alu_result & ~32'h1).
  - else b_jal: pc+imm.
  - else b_beq & alu_zero: pc+imm.
  - else pc+4.
- All adds are modulo 2^32; pc 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no error.
- Misalignment check: if next_pc[1:0]!=0 when leaving ISSUE, pc is still loaded with next_pc, misaligned is set, and state goes to HALT instead of FETCH.
- Input sampling rules:
  - b_*, alu_zero, imm and alu_result are sampled only in ISSUE with stall=0; ignored in all other states.
  - stall is ignored outside ISSUE.
- Throughput: minimum 2 cycles per instruction (FETCH with ready, then ISSUE); each cycle of imem_ready=0 adds one cycle.
- imem_rdata is captured only on a cycle where imem_req=1 and imem_ready=1. imem_ready in IDLE, ISSUE or HALT is ignored.
- Reset mid-operation (WAIT, ISSUE or HALT): the outstanding request is abandoned. The cycle after the rst edge shows imem_req=0, state IDLE and pc=RESET_PC.

Test Plan:
- Sequential fetch: RESET_PC=0, imem_ready=1, no branches. After rst release imem_addr steps 0x0, 0x4, 0x8 on FETCH cycles. inst_valid pulses every 2nd cycle and inst equals the imem_rdata returned for each address.
- Wait states: imem_ready low for 3 cycles at pc=0x4. imem_req and imem_addr=0x4 are held stable for 4 cycles. inst_valid rises the cycle after ready, with inst=0x00500093.
- beq taken/not taken: pc=0x10, b_beq=1, imm=0xFFFF_FFF8. With alu_zero=1 the next imem_addr is 0x08; with alu_zero=0 it is 0x14.
- Jump priority: b_jal=1, b_jalr=1, alu_result=0x101, imm=0x40 -> next pc=0x100. With b_jal alone at pc=0x20, imm=0x40 -> 0x60. pc_plus4=0x24 during that ISSUE.
- Misaligned target: b_jal=1, imm=0x6 at pc=0x0. Next cycle pc=0x6, misaligned=1, imem_req=0. These hold for 10 cycles until rst, which clears misaligned and restarts at 0x0.
- Stall and reset: stall=1 for 3 cycles in ISSUE keeps pc, inst and inst_valid=1 unchanged. Then rst asserted during WAIT gives pc=RESET_PC, imem_req=0 and inst_valid=0 the next cycle.
